// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- ID-stage main control decoder plus load-use hazard unit
// for a classic 5-stage pipeline, carrying the decoded control bits
// through the ID/EX, EX/MEM and MEM/WB registers.
//
// Parameters:
//   RA_W       register-address width
//   STALL_CYC  load-use stall length in cycles (1..3)
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   Op_i              ID-stage opcode
//   Rs_i, Rt_i        ID-stage source registers
//   branch_eq_i       ID-stage rs==rt compare result
//   pc_write_o        PC enable
//   ifid_write_o      IF/ID enable
//   ifid_flush_o      IF/ID flush (taken branch or jump)
//   jump_o, branch_o  taken jump / taken branch
//   stall_o           load-use stall active
//   illegal_o         unknown opcode in ID
//   EX_o              {ALUSrc, ALUOp[1:0], RegDst} from ID/EX
//   MEM_o             {MemWrite, MemRead} from EX/MEM
//   WB_o              {RegWrite, MemtoReg} from MEM/WB
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal issue; a detected load-use hazard stalls this cycle
// STALL | extra stall cycles while cnt counts down to 1
module ctrl_pipe #(
    parameter int RA_W      = 5,
    parameter int STALL_CYC = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      Op_i,
    input  logic [RA_W-1:0] Rs_i,
    input  logic [RA_W-1:0] Rt_i,
    input  logic            branch_eq_i,
    output logic            pc_write_o,
    output logic            ifid_write_o,
    output logic            ifid_flush_o,
    output logic            jump_o,
    output logic            branch_o,
    output logic            stall_o,
    output logic            illegal_o,
    output logic [3:0]      EX_o,
    output logic [1:0]      MEM_o,
    output logic [1:0]      WB_o
);

    localparam int CNT_W = $clog2(STALL_CYC + 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    generate
        if (STALL_CYC < 1 || STALL_CYC > 3) begin : g_bad_stall_cyc
            $error("ctrl_pipe: STALL_CYC must be 1..3");
        end
    endgenerate

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [3:0] dec_ex;
    logic [1:0] dec_mem;
    logic [1:0] dec_wb;
    logic       dec_illegal;
    logic       uses_rt;
    logic       hazard;
    logic       stall;

    logic [3:0]      idex_ex;
    logic [1:0]      idex_mem;
    logic [1:0]      idex_wb;
    logic [RA_W-1:0] idex_rt;
    logic [1:0]      exmem_mem;
    logic [1:0]      exmem_wb;
    logic [1:0]      memwb_wb;

    always_comb begin
        dec_ex      = 4'b0000;
        dec_mem     = 2'b00;
        dec_wb      = 2'b00;
        dec_illegal = 1'b0;
        uses_rt     = 1'b0;
        case (Op_i)
            OP_R: begin
                dec_ex  = 4'b0101;
                dec_wb  = 2'b10;
                uses_rt = 1'b1;
            end
            OP_ADDI: begin
                dec_ex = 4'b1000;
                dec_wb = 2'b10;
            end
            OP_LW: begin
                dec_ex  = 4'b1000;
                dec_mem = 2'b01;
                dec_wb  = 2'b11;
            end
            OP_SW: begin
                dec_ex  = 4'b1000;
                dec_mem = 2'b10;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                dec_ex  = 4'b0010;
                uses_rt = 1'b1;
            end
            OP_J: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Rt only counts as a source for opcodes that actually read it.
    assign hazard = idex_mem[0] && (idex_rt != '0) &&
                    ((idex_rt == Rs_i) || (uses_rt && (idex_rt == Rt_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The RUN cycle that detects the hazard is the first stall cycle, so
    // STALL only covers the remaining STALL_CYC-1 cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (STALL_CYC > 1) begin
                        state_next = STALL;
                        cnt_next   = CNT_W'(STALL_CYC - 1);
                    end
                end
            end
            STALL: begin
                stall    = 1'b1;
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign stall_o      = stall;
    assign pc_write_o   = ~stall;
    assign ifid_write_o = ~stall;
    assign jump_o       = (Op_i == OP_J) && !stall;
    assign branch_o     = (Op_i == OP_BEQ) && branch_eq_i && !stall;
    assign ifid_flush_o = jump_o | branch_o;
    assign illegal_o    = dec_illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_ex   <= '0;
            idex_mem  <= '0;
            idex_wb   <= '0;
            idex_rt   <= '0;
            exmem_mem <= '0;
            exmem_wb  <= '0;
            memwb_wb  <= '0;
        end else begin
            idex_ex   <= stall ? 4'b0000 : dec_ex;
            idex_mem  <= stall ? 2'b00   : dec_mem;
            idex_wb   <= stall ? 2'b00   : dec_wb;
            idex_rt   <= stall ? '0      : Rt_i;
            exmem_mem <= idex_mem;
            exmem_wb  <= idex_wb;
            memwb_wb  <= exmem_wb;
        end
    end

    assign EX_o  = idex_ex;
    assign MEM_o = exmem_mem;
    assign WB_o  = memwb_wb;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (STALL_CYC=1 and STALL_CYC=3) share
// the same stimulus. A vector table covers decode and pipeline latency;
// hand sequences cover load-use stalls, branch-vs-stall and reset mid-stall.
module tb_ctrl_pipe;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op  = 6'b0;
    logic [4:0] rs  = 5'd0;
    logic [4:0] rt  = 5'd0;
    logic       eq  = 1'b0;

    logic       u1_pcw, u1_ifw, u1_flush, u1_jump, u1_br, u1_stall, u1_ill;
    logic [3:0] u1_ex;
    logic [1:0] u1_mem, u1_wb;
    logic       u3_pcw, u3_ifw, u3_flush, u3_jump, u3_br, u3_stall, u3_ill;
    logic [3:0] u3_ex;
    logic [1:0] u3_mem, u3_wb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.RA_W(5), .STALL_CYC(1)) u1 (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .Rs_i(rs), .Rt_i(rt),
        .branch_eq_i(eq), .pc_write_o(u1_pcw), .ifid_write_o(u1_ifw),
        .ifid_flush_o(u1_flush), .jump_o(u1_jump), .branch_o(u1_br),
        .stall_o(u1_stall), .illegal_o(u1_ill), .EX_o(u1_ex),
        .MEM_o(u1_mem), .WB_o(u1_wb)
    );

    ctrl_pipe #(.RA_W(5), .STALL_CYC(3)) u3 (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .Rs_i(rs), .Rt_i(rt),
        .branch_eq_i(eq), .pc_write_o(u3_pcw), .ifid_write_o(u3_ifw),
        .ifid_flush_o(u3_flush), .jump_o(u3_jump), .branch_o(u3_br),
        .stall_o(u3_stall), .illegal_o(u3_ill), .EX_o(u3_ex),
        .MEM_o(u3_mem), .WB_o(u3_wb)
    );

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       eq;
        logic [3:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
        logic       jmp;
        logic       br;
        logic       ill;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one ID-stage instruction just after the edge, then sample at the
    // following falling edge.
    task automatic step(input logic [5:0] o, input logic [4:0] s,
                        input logic [4:0] t, input logic e);
        @(posedge clk);
        #1;
        op = o; rs = s; rt = t; eq = e;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic [4:0] s,
                                input logic [4:0] t, input logic e,
                                input logic [3:0] x, input logic [1:0] m,
                                input logic [1:0] w, input logic jm,
                                input logic b, input logic il);
        vec_t v;
        v.op = o; v.rs = s; v.rt = t; v.eq = e;
        v.ex = x; v.mem = m; v.wb = w; v.jmp = jm; v.br = b; v.ill = il;
        return v;
    endfunction

    logic [14:0] exp_v;

    initial begin
        // Each row: ID-stage inputs this cycle, plus EX from the row before,
        // MEM from two rows before and WB from three rows before.
        tbl[0]  = mk(R,    1, 2, 0, 4'b0000, 2'b00, 2'b00, 0, 0, 0);
        tbl[1]  = mk(LW,   3, 9, 0, 4'b0101, 2'b00, 2'b00, 0, 0, 0);
        tbl[2]  = mk(SW,   4, 5, 0, 4'b1000, 2'b00, 2'b00, 0, 0, 0);
        tbl[3]  = mk(ADDI, 6, 7, 0, 4'b1000, 2'b01, 2'b10, 0, 0, 0);
        tbl[4]  = mk(BEQ,  1, 2, 0, 4'b1000, 2'b10, 2'b11, 0, 0, 0);
        tbl[5]  = mk(J,    0, 0, 0, 4'b0010, 2'b00, 2'b00, 1, 0, 0);
        tbl[6]  = mk(BAD,  0, 0, 0, 4'b0000, 2'b00, 2'b10, 0, 0, 1);
        tbl[7]  = mk(BEQ,  1, 2, 1, 4'b0000, 2'b00, 2'b00, 0, 1, 0);
        tbl[8]  = mk(R,    0, 0, 0, 4'b0010, 2'b00, 2'b00, 0, 0, 0);
        tbl[9]  = mk(ADDI, 0, 0, 0, 4'b0101, 2'b00, 2'b00, 0, 0, 0);
        tbl[10] = mk(J,    0, 0, 1, 4'b1000, 2'b00, 2'b00, 1, 0, 0);

        // Reset values, with combinational outputs following Op_i.
        op = J;
        #3;
        chk("rst u1 pcw", u1_pcw, 1);
        chk("rst u1 ifw", u1_ifw, 1);
        chk("rst u1 stall", u1_stall, 0);
        chk("rst u1 ex", u1_ex, 0);
        chk("rst u1 mem", u1_mem, 0);
        chk("rst u1 wb", u1_wb, 0);
        chk("rst u1 jump", u1_jump, 1);
        chk("rst u1 flush", u1_flush, 1);
        op = BEQ; eq = 1'b1;
        #1;
        chk("rst u3 branch", u3_br, 1);
        op = BAD;
        #1;
        chk("rst u3 illegal", u3_ill, 1);
        op = J; eq = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].eq);
            exp_v = {1'b1, 1'b1, tbl[i].jmp | tbl[i].br, tbl[i].jmp, tbl[i].br,
                     1'b0, tbl[i].ill, tbl[i].ex, tbl[i].mem, tbl[i].wb};
            chk($sformatf("vec%0d u1", i),
                {u1_pcw, u1_ifw, u1_flush, u1_jump, u1_br, u1_stall, u1_ill,
                 u1_ex, u1_mem, u1_wb}, exp_v);
            chk($sformatf("vec%0d u3", i),
                {u3_pcw, u3_ifw, u3_flush, u3_jump, u3_br, u3_stall, u3_ill,
                 u3_ex, u3_mem, u3_wb}, exp_v);
        end

        // Load-use: lw r8, then R reading r8 held in ID while stalled.
        step(LW, 0, 8, 0);
        step(R, 8, 1, 0);
        chk("lu b u1 pcw", u1_pcw, 0);
        chk("lu b u1 stall", u1_stall, 1);
        chk("lu b u1 ex", u1_ex, 4'b1000);
        chk("lu b u3 stall", u3_stall, 1);
        step(R, 8, 1, 0);
        chk("lu c u1 stall", u1_stall, 0);
        chk("lu c u1 pcw", u1_pcw, 1);
        chk("lu c u1 ex", u1_ex, 4'b0000);
        chk("lu c u3 stall", u3_stall, 1);
        chk("lu c u3 ex", u3_ex, 4'b0000);
        step(R, 8, 1, 0);
        chk("lu d u1 ex", u1_ex, 4'b0101);
        chk("lu d u1 stall", u1_stall, 0);
        chk("lu d u3 stall", u3_stall, 1);
        chk("lu d u3 ex", u3_ex, 4'b0000);
        chk("lu d u3 wb", u3_wb, 2'b11);
        step(R, 8, 1, 0);
        chk("lu e u3 stall", u3_stall, 0);
        chk("lu e u3 pcw", u3_pcw, 1);
        chk("lu e u3 ex", u3_ex, 4'b0000);
        chk("lu e u3 wb", u3_wb, 2'b00);
        step(ADDI, 0, 0, 0);
        chk("lu f u3 ex", u3_ex, 4'b0101);
        chk("lu f u3 wb", u3_wb, 2'b00);
        step(ADDI, 0, 0, 0);
        chk("lu g u3 wb", u3_wb, 2'b00);
        step(ADDI, 0, 0, 0);
        chk("lu h u3 wb", u3_wb, 2'b10);

        // lw to r0 never stalls.
        step(LW, 0, 0, 0);
        step(R, 0, 1, 0);
        chk("lw r0 u1 stall", u1_stall, 0);
        chk("lw r0 u3 stall", u3_stall, 0);
        chk("lw r0 u3 pcw", u3_pcw, 1);

        // Taken beq behind a load of its Rt: stall wins, branch after.
        step(LW, 0, 4, 0);
        step(BEQ, 1, 4, 1);
        chk("br b u1 branch", u1_br, 0);
        chk("br b u1 flush", u1_flush, 0);
        chk("br b u3 branch", u3_br, 0);
        step(BEQ, 1, 4, 1);
        chk("br c u1 branch", u1_br, 1);
        chk("br c u1 flush", u1_flush, 1);
        chk("br c u3 branch", u3_br, 0);
        step(BEQ, 1, 4, 1);
        chk("br d u3 branch", u3_br, 0);
        chk("br d u3 stall", u3_stall, 1);
        step(BEQ, 1, 4, 1);
        chk("br e u3 branch", u3_br, 1);
        chk("br e u3 flush", u3_flush, 1);
        chk("br e u3 stall", u3_stall, 0);

        // Reset pulsed during the second cycle of a 3-cycle stall.
        step(LW, 0, 8, 0);
        step(R, 8, 1, 0);
        step(R, 8, 1, 0);
        chk("rs c u3 stall", u3_stall, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rs u3 stall", u3_stall, 0);
        chk("rs u3 pcw", u3_pcw, 1);
        chk("rs u3 ifw", u3_ifw, 1);
        chk("rs u3 ex", u3_ex, 0);
        chk("rs u3 mem", u3_mem, 0);
        chk("rs u3 wb", u3_wb, 0);
        @(negedge clk);
        rst = 1'b0;
        step(R, 8, 1, 0);
        chk("rs rel u3 pcw", u3_pcw, 1);
        chk("rs rel u3 stall", u3_stall, 0);
        chk("rs rel u3 ex", u3_ex, 4'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
